// File: rtl/health_test_sched_if.sv
// Purpose : bundles the scheduler's source, controller and test-engine signals.
// Ports   : req/src_bit/tst_pass into the scheduler; gnt/done/result/fail_lat/busy/tst_rst/tst_rand out.
// Modports: slave = scheduler side, master = environment (sources, controller, engine).
interface health_test_sched_if;
    logic [1:0] req;       // per-source test request, level
    logic [1:0] src_bit;   // per-source random bit
    logic [1:0] gnt;       // one-hot grant
    logic [1:0] done;      // per-source completion pulse
    logic [1:0] result;    // per-source last outcome, 1 = pass
    logic [1:0] fail_lat;  // sticky per-source failure
    logic       busy;      // scheduler not idle
    logic       tst_rst;   // synchronous clear to the engine
    logic       tst_rand;  // bit stream to the engine
    logic       tst_pass;  // engine verdict

    modport slave (
        input  req, src_bit, tst_pass,
        output gnt, done, result, fail_lat, busy, tst_rst, tst_rand
    );

    modport master (
        output req, src_bit, tst_pass,
        input  gnt, done, result, fail_lat, busy, tst_rst, tst_rand
    );
endinterface

// File: rtl/health_test_sched.sv
// Purpose : time-shares one runs/monobit test engine between two entropy sources, round-robin, with retry.
// Latency : grant one cycle after req; one attempt = 1 + N + RES_LAT + 1 cycles; done on the edge leaving DONE.
// Backpressure: none; a source holds req until its done, dropping it mid-test aborts the attempt.
// Ports   : i_clk, i_rst_n (async active-low), bus (health_test_sched_if.slave).
module health_test_sched #(
    parameter int N         = 20000,  // bits per test window, 2..32767
    parameter int RES_LAT   = 2,      // engine decision latency in cycles, 1..8
    parameter int MAX_RETRY = 1       // retries after a failed attempt, 0..3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    health_test_sched_if.slave   bus
);

    localparam logic [14:0] LP_BCNT_LAST = 15'(N - 1);
    localparam logic [2:0]  LP_WCNT_LAST = 3'(RES_LAT - 1);
    localparam logic [1:0]  LP_MAX_RETRY = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_STREAM = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      r_state;
    logic [1:0]  r_gnt;
    logic        r_gidx;     // index of the granted source
    logic        r_rr;       // source with priority at the next IDLE decision
    logic [1:0]  r_retry;
    logic [14:0] r_bcnt;
    logic [2:0]  r_wcnt;
    logic [1:0]  r_done;
    logic [1:0]  r_result;
    logic [1:0]  r_fail;
    logic        r_busy;
    logic        r_tst_rst;

    logic        w_req_g;
    logic        w_pick;
    logic        w_tst_rand;

    // Request of the source currently under test; low means abort.
    assign w_req_g = bus.req[r_gidx];

    // Round-robin pick: rr wins if requesting, otherwise the other source.
    assign w_pick  = bus.req[r_rr] ? r_rr : ~r_rr;

    // The engine only ever sees live source bits while streaming.
    assign w_tst_rand = (r_state == S_STREAM) ? bus.src_bit[r_gidx] : 1'b0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_gnt     <= 2'b00;
            r_gidx    <= 1'b0;
            r_rr      <= 1'b0;
            r_retry   <= 2'd0;
            r_bcnt    <= 15'd0;
            r_wcnt    <= 3'd0;
            r_done    <= 2'b00;
            r_result  <= 2'b00;
            r_fail    <= 2'b00;
            r_busy    <= 1'b0;
            r_tst_rst <= 1'b1;
        end else begin
            r_done <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    r_retry   <= 2'd0;
                    r_tst_rst <= 1'b1;
                    if (|bus.req) begin
                        r_gidx  <= w_pick;
                        r_gnt   <= w_pick ? 2'b10 : 2'b01;
                        r_state <= S_CLR;
                        r_busy  <= 1'b1;
                    end
                end

                S_CLR: begin
                    r_bcnt <= 15'd0;
                    if (!w_req_g) begin
                        r_state   <= S_IDLE;
                        r_gnt     <= 2'b00;
                        r_busy    <= 1'b0;
                        r_tst_rst <= 1'b1;
                    end else begin
                        r_state   <= S_STREAM;
                        r_tst_rst <= 1'b0;
                    end
                end

                S_STREAM: begin
                    if (!w_req_g) begin
                        r_state   <= S_IDLE;
                        r_gnt     <= 2'b00;
                        r_busy    <= 1'b0;
                        r_tst_rst <= 1'b1;
                    end else if (r_bcnt == LP_BCNT_LAST) begin
                        // Compare before increment so the counter never wraps.
                        r_state <= S_WAIT;
                        r_wcnt  <= 3'd0;
                    end else begin
                        r_bcnt <= r_bcnt + 15'd1;
                    end
                end

                S_WAIT: begin
                    if (!w_req_g) begin
                        r_state   <= S_IDLE;
                        r_gnt     <= 2'b00;
                        r_busy    <= 1'b0;
                        r_tst_rst <= 1'b1;
                    end else if (r_wcnt == LP_WCNT_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_wcnt <= r_wcnt + 3'd1;
                    end
                end

                S_DONE: begin
                    if (!bus.tst_pass && (r_retry < LP_MAX_RETRY)) begin
                        // Retry: keep the grant, re-clear the engine, no report yet.
                        r_retry   <= r_retry + 2'd1;
                        r_state   <= S_CLR;
                        r_tst_rst <= 1'b1;
                    end else begin
                        r_result[r_gidx] <= bus.tst_pass;
                        if (!bus.tst_pass) begin
                            r_fail[r_gidx] <= 1'b1;
                        end
                        r_done[r_gidx] <= 1'b1;
                        r_rr           <= ~r_gidx;
                        r_state        <= S_IDLE;
                        r_gnt          <= 2'b00;
                        r_busy         <= 1'b0;
                        r_tst_rst      <= 1'b1;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_gnt     <= 2'b00;
                    r_busy    <= 1'b0;
                    r_tst_rst <= 1'b1;
                end
            endcase
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.fail_lat = r_fail;
    assign bus.busy     = r_busy;
    assign bus.tst_rst  = r_tst_rst;
    assign bus.tst_rand = w_tst_rand;

endmodule

// File: tb/tb_health_test_sched.sv
// Purpose : self-checking bench for health_test_sched with N=16, RES_LAT=2, MAX_RETRY=1.
// Latency : expects grant one cycle after req and done 20 cycles per attempt after grant.
// Backpressure: none; a behavioural engine model supplies the verdict.
module tb_health_test_sched;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    health_test_sched_if ifc();

    health_test_sched #(
        .N         (16),
        .RES_LAT   (2),
        .MAX_RETRY (1)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifc)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Sources: source 0 streams 0101..., source 1 streams 0011...
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    assign ifc.src_bit = {cyc[1], cyc[0]};

    // Behavioural engine: records the first 16 bits after a clear, counts attempts
    // (clear-to-run transitions), and fails the first fails_now attempts after att_base.
    logic        prev_rst = 1'b1;
    int          nbits    = 0;
    int          ones     = 0;
    int          attempts = 0;
    logic [15:0] cap      = '0;
    int          att_base = 0;
    int          fails_now = 0;

    always @(posedge clk) begin
        prev_rst <= ifc.tst_rst;
        if (ifc.tst_rst) begin
            nbits <= 0;
            ones  <= 0;
            cap   <= '0;
        end else begin
            if (prev_rst) attempts <= attempts + 1;
            if (nbits < 16) begin
                nbits <= nbits + 1;
                ones  <= ones + int'(ifc.tst_rand);
                cap   <= {cap[14:0], ifc.tst_rand};
            end
        end
    end

    assign ifc.tst_pass = ((attempts - att_base) > fails_now) && (nbits == 16)
                          && (ones >= 4) && (ones <= 12);

    typedef struct {
        logic [1:0] req;
        int         fails;
        logic [1:0] exp_gnt;
        int         exp_lat;
        logic [1:0] exp_result;
        logic [1:0] exp_fail;
    } vec_t;

    vec_t vt[6];

    initial begin
        int t, lows, serr, gerr, ngr, zeros, ndone, overlap, dcnt;
        logic seen;
        logic [1:0] pg;
        logic [1:0] gseq[3];
        int gaps[2];

        // inputs: req, engine failures; expected: gnt, latency, result, fail_lat
        vt[0] = '{2'b01, 0, 2'b01, 20, 2'b01, 2'b00};  // single pass
        vt[1] = '{2'b01, 1, 2'b01, 40, 2'b01, 2'b00};  // retry then pass
        vt[2] = '{2'b10, 0, 2'b10, 20, 2'b11, 2'b00};  // source 1 pass
        vt[3] = '{2'b01, 2, 2'b01, 40, 2'b10, 2'b01};  // retry exhausted
        vt[4] = '{2'b01, 0, 2'b01, 20, 2'b11, 2'b01};  // pass, fail_lat sticky
        vt[5] = '{2'b10, 5, 2'b10, 40, 2'b01, 2'b11};  // source 1 exhausted

        ifc.req = 2'b00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt",      32'(ifc.gnt),      32'h0);
        chk("rst_done",     32'(ifc.done),     32'h0);
        chk("rst_result",   32'(ifc.result),   32'h0);
        chk("rst_fail_lat", 32'(ifc.fail_lat), 32'h0);
        chk("rst_busy",     32'(ifc.busy),     32'h0);
        chk("rst_tst_rst",  32'(ifc.tst_rst),  32'h1);
        chk("rst_tst_rand", 32'(ifc.tst_rand), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(ifc.busy), 32'h0);

        // Table-driven single-request sequences
        for (int i = 0; i < 6; i++) begin
            att_base  = attempts;
            fails_now = vt[i].fails;
            ifc.req   = vt[i].req;
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i),  32'(ifc.gnt),  32'(vt[i].exp_gnt));
            chk($sformatf("v%0d_busy", i), 32'(ifc.busy), 32'h1);
            t = 0; lows = 0; serr = 0; gerr = 0; seen = 1'b0;
            while (t < 200 && !seen) begin
                @(negedge clk);
                t++;
                if (!ifc.tst_rst) lows++;
                if (!ifc.tst_rst && nbits < 16 && ifc.tst_rand !== ifc.src_bit[ifc.gnt[1]]) serr++;
                if (ifc.done != 2'b00) seen = 1'b1;
                else if (ifc.gnt !== vt[i].exp_gnt) gerr++;
            end
            chk($sformatf("v%0d_latency", i),  32'(t),            32'(vt[i].exp_lat));
            chk($sformatf("v%0d_done", i),     32'(ifc.done),     32'(vt[i].exp_gnt));
            chk($sformatf("v%0d_gnt_fall", i), 32'(ifc.gnt),      32'h0);
            chk($sformatf("v%0d_result", i),   32'(ifc.result),   32'(vt[i].exp_result));
            chk($sformatf("v%0d_fail_lat", i), 32'(ifc.fail_lat), 32'(vt[i].exp_fail));
            chk($sformatf("v%0d_gnt_held", i), 32'(gerr),         32'h0);
            chk($sformatf("v%0d_stream", i),   32'(serr),         32'h0);
            chk($sformatf("v%0d_run_cycles", i), 32'(lows), 32'((vt[i].exp_lat / 20) * 19));
            chk($sformatf("v%0d_nbits", i),    32'(nbits),        32'd16);
            if (vt[i].req == 2'b01)
                chk($sformatf("v%0d_pattern", i),
                    32'((cap == 16'h5555) || (cap == 16'hAAAA)), 32'h1);
            ifc.req = 2'b00;
            @(negedge clk);
            chk($sformatf("v%0d_idle", i), 32'(ifc.busy), 32'h0);
        end

        // Arbitration: both requesting, grants alternate with one idle cycle between
        att_base = attempts; fails_now = 0;
        ifc.req = 2'b11;
        ngr = 0; zeros = 0; ndone = 0; overlap = 0; t = 0; pg = 2'b00;
        gseq[0] = 2'b00; gseq[1] = 2'b00; gseq[2] = 2'b00; gaps[0] = -1; gaps[1] = -1;
        while (ndone < 3 && t < 300) begin
            @(negedge clk);
            t++;
            if (ifc.gnt == 2'b11) overlap++;
            if (ifc.gnt != 2'b00 && pg == 2'b00) begin
                if (ngr < 3) gseq[ngr] = ifc.gnt;
                if (ngr > 0 && ngr < 3) gaps[ngr-1] = zeros;
                ngr++;
                zeros = 0;
            end
            if (ifc.gnt == 2'b00) zeros++;
            if (ifc.done != 2'b00) ndone++;
            pg = ifc.gnt;
        end
        ifc.req = 2'b00;
        chk("arb_ndone",   32'(ndone),      32'd3);
        chk("arb_g0",      32'(gseq[0]),    32'h1);
        chk("arb_g1",      32'(gseq[1]),    32'h2);
        chk("arb_g2",      32'(gseq[2]),    32'h1);
        chk("arb_gap0",    32'(gaps[0]),    32'd1);
        chk("arb_gap1",    32'(gaps[1]),    32'd1);
        chk("arb_overlap", 32'(overlap),    32'd0);
        chk("arb_result",  32'(ifc.result), 32'h3);
        @(negedge clk);
        chk("arb_idle", 32'(ifc.busy), 32'h0);

        // Abort: drop req[1] during stream bit 7
        att_base = attempts; fails_now = 0;
        ifc.req = 2'b10;
        @(negedge clk);
        chk("abort_gnt", 32'(ifc.gnt), 32'h2);
        repeat (8) @(negedge clk);
        chk("abort_bitpos", 32'(nbits), 32'd7);
        ifc.req = 2'b00;
        @(negedge clk);
        chk("abort_gnt0",    32'(ifc.gnt),     32'h0);
        chk("abort_busy",    32'(ifc.busy),    32'h0);
        chk("abort_tst_rst", 32'(ifc.tst_rst), 32'h1);
        dcnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (ifc.done != 2'b00) dcnt++;
            @(negedge clk);
        end
        chk("abort_no_done",  32'(dcnt),         32'd0);
        chk("abort_result",   32'(ifc.result),   32'h3);
        chk("abort_fail_lat", 32'(ifc.fail_lat), 32'h3);

        // Asynchronous reset mid-stream
        ifc.req = 2'b01;
        repeat (6) @(negedge clk);
        chk("mid_busy_before", 32'(ifc.busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt",      32'(ifc.gnt),      32'h0);
        chk("mid_rst_busy",     32'(ifc.busy),     32'h0);
        chk("mid_rst_tst_rst",  32'(ifc.tst_rst),  32'h1);
        chk("mid_rst_fail_lat", 32'(ifc.fail_lat), 32'h0);
        chk("mid_rst_result",   32'(ifc.result),   32'h0);
        chk("mid_rst_tst_rand", 32'(ifc.tst_rand), 32'h0);
        ifc.req = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ifc.busy || ifc.gnt != 2'b00 || ifc.done != 2'b00) dcnt++;
        end
        chk("post_rst_quiet", 32'(dcnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/health_test_sched.md
# health_test_sched

- Schedules one shared runs/monobit statistical test engine between two entropy sources, e.g. PUF-derived TRNG channels.
- Arbitrates round-robin between per-source test requests.
- For the granted source, the block:
  - clears the engine;
  - streams exactly N bits from that source into it;
  - waits for the engine's decision latency;
  - samples the pass flag.
- Failed tests retry up to MAX_RETRY times before the source is latched as failed.
- Per-source results and done pulses go to the system controller.

## Interface
Parameters:
- N, 20000: bits per test window; must fit 15 bits, N ≥ 2.
- RES_LAT, 2: cycles from the last streamed bit until tst_pass is valid; ≥ 1.
- MAX_RETRY, 1: retries after a failed attempt before declaring failure; 0..3.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  2  per-source test request; level, held until the matching done.
- src_bit  in  2  per-source random bit, one new bit per clock.
- gnt  out  2  one-hot grant to the source being tested; 0 when idle.
- done  out  2  one-cycle pulse per source when its test sequence completes.
- result  out  2  per-source outcome of the last completed sequence; 1 = pass; held.
- fail_lat  out  2  sticky per-source failure flag; cleared only by rst.
- busy  out  1  1 whenever state ≠ IDLE.
- tst_rst  out  1  active-high synchronous clear to the test engine.
- tst_rand  out  1  bit stream to the test engine.
- tst_pass  in  1  test engine verdict.

## Operation
- Reset (rst=0):
  - gnt, done, result, fail_lat and busy = 0.
  - tst_rst = 1, tst_rand = 0.
  - state = IDLE; rr pointer = 0; retry count = 0; bit counter = 0.
- States: IDLE → CLR → STREAM → WAIT → DONE → IDLE, or DONE → CLR on retry.
- IDLE:
  - tst_rst = 1.
  - If any req bit is set, pick a source round-robin: priority starts at source rr and passes to the other source next.
  - Load gnt and enter CLR.
  - Retry count = 0.
- CLR:
  - Lasts one cycle; tst_rst = 1; bit counter = 0.
- STREAM:
  - tst_rst = 0.
  - tst_rand = src_bit[granted] (combinational mux); tst_rand = 0 in every other state.
  - Bit counter increments each cycle; leave after count N-1, i.e. exactly N bits streamed.
- WAIT:
  - Hold tst_rst = 0; count RES_LAT cycles.
- DONE (one cycle; sample tst_pass):
  - Pass: result[g] = 1; done[g] pulses; rr = other source; go to IDLE, gnt = 0.
  - Fail with retry count < MAX_RETRY: increment retry count; go to CLR keeping gnt; no done, result unchanged.
  - Fail with retry count = MAX_RETRY: result[g] = 0, fail_lat[g] = 1, done[g] pulses; rr = other source; go to IDLE.
- Abort: if req[g] drops in CLR, STREAM or WAIT:
  - next state IDLE, gnt = 0, tst_rst = 1;
  - no done; result and fail_lat unchanged.
- Width rules:
  - Bit counter is 15 bits and never wraps: it is compared with N-1 before incrementing.
  - The WAIT counter is 3 bits.
  - The retry counter is 2 bits.

## Timing
- gnt is registered: it rises on the edge after req is seen in IDLE.
- One attempt takes 1 (CLR) + N (STREAM) + RES_LAT (WAIT) + 1 (DONE) cycles.
- done and result update on the edge that leaves DONE; gnt falls on that same edge.
- Back-to-back requests: a new IDLE decision happens the cycle after done. Minimum gap between tests is 1 idle cycle.
- Both req set in IDLE: the source pointed to by rr wins. After completion the other source wins if still requesting.
- A req held high after its done causes a fresh sequence (re-test); retry count resets.
- An asynchronous rst assertion mid-STREAM immediately forces reset values.
- Test engine state is not relied on after reset; CLR always precedes STREAM.

## Test plan
Use N=16, RES_LAT=2, MAX_RETRY=1 and a behavioural engine model.

- Reset: rst=0 mid-stream → same cycle: gnt=0, busy=0, tst_rst=1, fail_lat=0; after release, IDLE with no activity until req.
- Single pass:
  - Stimulus: req=01, src_bit[0] pattern 0101…, model passes.
  - Required: gnt=01 one cycle after req.
  - Required: tst_rand reproduces exactly 16 bits.
  - Required: done=01 exactly 20 cycles after gnt rises; result[0]=1.
- Retry then pass: model fails the first attempt and passes the second → no done after attempt 1; CLR re-entered with gnt held; done[0] at 40 cycles; result[0]=1, fail_lat[0]=0.
- Retry exhausted: model always fails → done[0] after 2 attempts; result[0]=0, fail_lat[0]=1; fail_lat stays 1 through later passing tests until rst.
- Arbitration: req=11 held → grants alternate 01, 10, 01, each separated by one idle cycle; no overlap of gnt bits.
- Abort: req[1] dropped at STREAM bit 7 → next cycle IDLE, tst_rst=1, no done[1], result[1] unchanged.
